// File: rtl/fsa_adder_arbiter_if.sv
// Requester/result handshake bundle for fsa_adder_arbiter: four requesters with
// packed operands on one side, a single registered result channel on the other.
interface fsa_adder_arbiter_if;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [15:0] req_y;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_sum;
  logic [1:0]  res_tag;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_sum, res_tag
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_sum, res_tag
  );
endinterface

// File: rtl/fsa_adder_arbiter.sv
// Round-robin arbiter sharing one 8+4 carry-look-ahead adder between four requesters.
// Optional macro FSA_ARB_SAT_EN clamps any carry-out result to 9'h0FF.
module fsa_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  fsa_adder_arbiter_if.slave  bus,
  output logic [CNTW-1:0]     txn_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        sum_q, sum_d;
  logic [1:0]        tag_q, tag_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              grant_found;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [7:0]        op_x;
  logic [3:0]        op_y;
  logic [4:0]        lo_res;
  logic [4:0]        hi_res;
  logic [8:0]        raw_sum;
  logic [8:0]        add_res;
  logic              can_accept;
  logic              xfer;
  logic              consume;

  // 4-bit lookahead group: every carry is a flat sum of products of g/p and cin.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Search downward so the lowest offset from ptr_q is the one left standing.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign op_x = bus.req_x[{grant_idx, 3'b000} +: 8];
  assign op_y = bus.req_y[{grant_idx, 2'b00} +: 4];

  assign lo_res  = cla4(op_x[3:0], op_y, 1'b0);
  assign hi_res  = cla4(op_x[7:4], 4'h0, lo_res[4]);
  assign raw_sum = {hi_res, lo_res[3:0]};

`ifdef FSA_ARB_SAT_EN
  assign add_res = raw_sum[8] ? 9'h0FF : raw_sum;
`else
  assign add_res = raw_sum;
`endif

  assign can_accept = (state_q == EMPTY) || bus.res_ready;
  assign xfer       = can_accept && grant_found && !rst;
  assign consume    = (state_q == FULL) && bus.res_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (consume && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (xfer) begin
      state_d = FULL;
      sum_d   = add_res;
      tag_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
    end else if (consume) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_tag   = tag_q;
  assign txn_count     = cnt_q;

endmodule

// File: tb/tb_fsa_adder_arbiter.sv
// Scoreboard bench for fsa_adder_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares each consumed result.
module tb_fsa_adder_arbiter;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CNTW-1:0] txn_count;

  fsa_adder_arbiter_if bus ();

  fsa_adder_arbiter #(.NREQ(4), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] sum;
    logic [1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_sum(input logic [7:0] x, input logic [3:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {5'b0, y};
`ifdef FSA_ARB_SAT_EN
    if (s[8]) s = 9'h0FF;
`endif
    return s;
  endfunction

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h tag %0d, expected none", bus.res_sum, bus.res_tag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_sum", 32'(bus.res_sum), 32'(e.sum));
        check("res_tag", 32'(bus.res_tag), 32'(e.tag));
      end
    end
  end

  task automatic ready_chk(input logic [3:0] exp_ready, input bit push = 1'b1);
    @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (push && exp_ready[i]) begin
        sb_q.push_back({model_sum(bus.req_x[8*i +: 8], bus.req_y[4*i +: 4]), 2'(i)});
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] exp_ready, input bit push = 1'b1);
    ready_chk(exp_ready, push);
    adv();
  endtask

  initial begin
    int p;
    rst           = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    repeat (2) adv();

    // Requests during reset are never granted.
    bus.req_valid = 4'hF;
    step(4'b0000);
    rst           = 1'b0;
    bus.req_valid = 4'h0;
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_sum", 32'(bus.res_sum), 0);
    check("rst_res_tag", 32'(bus.res_tag), 0);
    check("rst_txn_count", 32'(txn_count), 0);

    // Single request, one-cycle latency.
    bus.req_x[7:0] = 8'h12;
    bus.req_y[3:0] = 4'h3;
    bus.req_valid  = 4'b0001;
    bus.res_ready  = 1'b1;
    step(4'b0001);
    bus.req_valid = 4'h0;
    ready_chk(4'b0000);
    check("first_valid", 32'(bus.res_valid), 1);
    check("first_sum", 32'(bus.res_sum), 32'h015);
    check("first_tag", 32'(bus.res_tag), 0);
    adv();

    // Pointer advanced to 1: with all valid, requester 1 wins.
    bus.req_valid = 4'hF;
    step(4'b0010);
    bus.req_valid = 4'h0;
    step(4'b0000);
    check("txn_after_two", 32'(txn_count), 2);

    // Back-to-back rotation from a fresh reset.
    rst = 1'b1;
    adv();
    rst = 1'b0;
    check("rst2_txn_count", 32'(txn_count), 0);
    bus.req_x     = 32'hA0_7F_33_01;
    bus.req_y     = 16'h9_E_5_2;
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b1;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    check("txn_after_four", 32'(txn_count), 4);
    bus.req_valid = 4'h0;
    step(4'b0000);
    check("txn_after_five", 32'(txn_count), 5);

    // Backpressure: result holds, no grants, pointer frozen.
    bus.req_valid = 4'hF;
    step(4'b0010);
    bus.res_ready   = 1'b0;
    bus.req_x[23:16] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = (c == 1) ? 4'b1011 : 4'hF;
      ready_chk(4'b0000);
      check("hold_valid", 32'(bus.res_valid), 1);
      check("hold_sum", 32'(bus.res_sum), 32'h038);
      check("hold_tag", 32'(bus.res_tag), 1);
      adv();
    end
    bus.req_x[23:16] = 8'hC8;
    bus.req_y[11:8]  = 4'h4;
    bus.res_ready    = 1'b1;
    step(4'b0100);
    bus.req_valid = 4'h0;
    step(4'b0000);
    check("txn_after_hold", 32'(txn_count), 7);

    // Carry-out case.
    bus.req_x[31:24] = 8'hFF;
    bus.req_y[15:12] = 4'hF;
    bus.req_valid    = 4'b1000;
    step(4'b1000);
    bus.req_valid = 4'h0;
    ready_chk(4'b0000);
`ifdef FSA_ARB_SAT_EN
    check("carry_sum", 32'(bus.res_sum), 32'h0FF);
`else
    check("carry_sum", 32'(bus.res_sum), 32'h10E);
`endif
    check("carry_tag", 32'(bus.res_tag), 3);
    adv();

    // Reset while FULL and stalled discards the result and the pointer.
    bus.req_x[15:8] = 8'h40;
    bus.req_y[7:4]  = 4'h1;
    bus.req_valid   = 4'b0010;
    bus.res_ready   = 1'b0;
    step(4'b0010, 1'b0);
    bus.req_valid = 4'b0110;
    step(4'b0000);
    rst = 1'b1;
    step(4'b0000);
    rst = 1'b0;
    check("midrst_res_valid", 32'(bus.res_valid), 0);
    check("midrst_txn_count", 32'(txn_count), 0);
    bus.res_ready = 1'b1;
    step(4'b0010);
    bus.req_valid = 4'h0;
    step(4'b0000);
    check("txn_post_midrst", 32'(txn_count), 1);

    // Counter saturation with continuous traffic.
    bus.req_valid = 4'hF;
    p = 2;
    for (int n = 0; n < 18; n++) begin
      step(4'(1 << p));
      p = (p + 1) % 4;
    end
    bus.req_valid = 4'h0;
    step(4'b0000);
    check("txn_saturated", 32'(txn_count), 32'(15));
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
